// File: rtl/phase_timer_if.sv
// Control/status bundle between the traffic-light controller and the phase timer.
// The controller owns the master side; the timer owns the slave side.
interface phase_timer_if;
  logic       load;
  logic [5:0] load_value;
  logic       pause;
  logic [5:0] remaining;
  logic       busy;
  logic       tick;
  logic       expired;

  modport master (
    output load, load_value, pause,
    input  remaining, busy, tick, expired
  );

  modport slave (
    input  load, load_value, pause,
    output remaining, busy, tick, expired
  );
endinterface

// File: rtl/phase_timer.sv
// Loadable seconds down-counter with built-in one-second prescaler.
// Runs one light phase per load and strobes expired when it reaches zero.
module phase_timer #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  phase_timer_if.slave  bus
);

  localparam int unsigned PCNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned SEC_W  = 6;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(TICKS_PER_SEC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q,   state_d;
  logic [PCNT_W-1:0]  pcnt_q,    pcnt_d;
  logic [SEC_W-1:0]   remaining_q, remaining_d;
  logic               busy_q,    busy_d;
  logic               tick_q,    tick_d;
  logic               expired_q, expired_d;

  // Next-state and output decode; load always wins and cancels any pending expiry.
  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    remaining_d = remaining_q;
    tick_d      = 1'b0;
    expired_d   = 1'b0;

    if (bus.load) begin
      remaining_d = bus.load_value;
      pcnt_d      = '0;
      if (bus.load_value != '0) begin
        state_d = RUN;
      end else begin
        state_d   = IDLE;
        expired_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (!bus.pause) begin
            if (pcnt_q == PCNT_MAX) begin
              pcnt_d      = '0;
              tick_d      = 1'b1;
              remaining_d = remaining_q - SEC_W'(1);
              if (remaining_q == SEC_W'(1)) begin
                expired_d = 1'b1;
                state_d   = IDLE;
              end
            end else begin
              pcnt_d = pcnt_q + PCNT_W'(1);
            end
          end
        end
        default: begin
          pcnt_d = '0;
        end
      endcase
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pcnt_q      <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      tick_q      <= tick_d;
      expired_q   <= expired_d;
    end
  end

  assign bus.remaining = remaining_q;
  assign bus.busy      = busy_q;
  assign bus.tick      = tick_q;
  assign bus.expired   = expired_q;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer: expected expiry edges are queued at load time
// and matched against every observed expired strobe.
module tb_phase_timer;

  localparam int unsigned T = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   exp_q[$];

  phase_timer_if dut_if();

  phase_timer #(.TICKS_PER_SEC(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    cyc = cyc + 1;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks = checks + 1;
    assert (obs === expv) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0d expected %0d", name, obs, expv);
    end
  endtask

  // Drive a one-cycle load; returns the edge number at which it was sampled.
  task automatic do_load(input logic [5:0] v, input int extra, output int n);
    dut_if.load       = 1'b1;
    dut_if.load_value = v;
    step();
    n = cyc;
    exp_q.push_back(n + int'(v) * int'(T) + extra);
    dut_if.load = 1'b0;
  endtask

  task automatic wait_expired(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (dut_if.expired === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  // Scoreboard: every expired strobe must match the oldest queued expiry edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && dut_if.expired === 1'b1) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $error("FAIL sb_unexpected_expired: observed edge %0d expected none", cyc);
        end else begin
          int e;
          e = exp_q.pop_front();
          assert (cyc === e) else begin
            errors = errors + 1;
            $error("FAIL sb_expired_edge: observed %0d expected %0d", cyc, e);
          end
        end
      end
    end
  end

  initial begin
    int n;
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    dut_if.load       = 1'b0;
    dut_if.load_value = '0;
    dut_if.pause      = 1'b0;
    step();
    step();
    chk("rst_remaining", 32'(dut_if.remaining), 32'd0);
    chk("rst_busy",      32'(dut_if.busy),      32'd0);
    chk("rst_tick",      32'(dut_if.tick),      32'd0);
    chk("rst_expired",   32'(dut_if.expired),   32'd0);
    rst_n = 1'b1;
    step();

    // Phase of 3 s: remaining 3,2,1,0 at edges 0,4,8,12
    do_load(6'd3, 0, n);
    chk("t1_load_remaining", 32'(dut_if.remaining), 32'd3);
    chk("t1_load_busy",      32'(dut_if.busy),      32'd1);
    chk("t1_load_tick",      32'(dut_if.tick),      32'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t1_tick",      32'(dut_if.tick),      32'((k % 4) == 0));
      chk("t1_remaining", 32'(dut_if.remaining), 32'(3 - k / 4));
      chk("t1_busy",      32'(dut_if.busy),      32'(k < 12));
      chk("t1_expired",   32'(dut_if.expired),   32'(k == 12));
    end
    step();
    chk("t1_post_expired", 32'(dut_if.expired), 32'd0);
    chk("t1_post_busy",    32'(dut_if.busy),    32'd0);

    // Zero-length phase expires immediately
    do_load(6'd0, 0, n);
    chk("t2_expired",   32'(dut_if.expired),   32'd1);
    chk("t2_busy",      32'(dut_if.busy),      32'd0);
    chk("t2_tick",      32'(dut_if.tick),      32'd0);
    chk("t2_remaining", 32'(dut_if.remaining), 32'd0);
    step();
    chk("t2_expired_once", 32'(dut_if.expired), 32'd0);
    chk("t2_busy_after",   32'(dut_if.busy),    32'd0);

    // Pause for 5 cycles starting at edge 2 of a 2 s phase
    do_load(6'd2, 5, n);
    step();
    dut_if.pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_pause_tick",      32'(dut_if.tick),      32'd0);
      chk("t3_pause_remaining", 32'(dut_if.remaining), 32'd2);
    end
    dut_if.pause = 1'b0;
    step();
    step();
    chk("t3_pre_tick", 32'(dut_if.tick), 32'd0);
    step();
    chk("t3_first_tick", 32'(dut_if.tick),      32'd1);
    chk("t3_first_rem",  32'(dut_if.remaining), 32'd1);
    wait_expired(10, "t3_expired_seen");
    chk("t3_expired_edge", 32'(cyc), 32'(n + 13));

    // Reload coinciding with a terminal prescaler count
    do_load(6'd5, 0, n);
    step();
    step();
    step();
    exp_q.delete();
    do_load(6'd2, 0, n);
    chk("t4_reload_edge",      32'(n - cyc), 32'd0);
    chk("t4_reload_remaining", 32'(dut_if.remaining), 32'd2);
    chk("t4_reload_tick",      32'(dut_if.tick),      32'd0);
    chk("t4_reload_expired",   32'(dut_if.expired),   32'd0);
    chk("t4_reload_busy",      32'(dut_if.busy),      32'd1);
    wait_expired(12, "t4_expired_seen");
    chk("t4_expired_edge", 32'(cyc), 32'(n + 8));

    // Asynchronous reset mid-phase
    do_load(6'd30, 0, n);
    for (int k = 0; k < 6; k++) step();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_rst_remaining", 32'(dut_if.remaining), 32'd0);
    chk("t5_rst_busy",      32'(dut_if.busy),      32'd0);
    chk("t5_rst_tick",      32'(dut_if.tick),      32'd0);
    chk("t5_rst_expired",   32'(dut_if.expired),   32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("t5_idle_busy",      32'(dut_if.busy),      32'd0);
    chk("t5_idle_remaining", 32'(dut_if.remaining), 32'd0);
    do_load(6'd2, 0, n);
    chk("t5_new_remaining", 32'(dut_if.remaining), 32'd2);
    wait_expired(12, "t5_expired_seen");
    chk("t5_expired_edge", 32'(cyc), 32'(n + 8));

    // Green then yellow, back to back on expired
    do_load(6'd30, 0, n);
    wait_expired(130, "t6_green_seen");
    chk("t6_green_edge", 32'(cyc), 32'(n + 120));
    do_load(6'd5, 0, n);
    wait_expired(30, "t6_yellow_seen");
    chk("t6_yellow_edge", 32'(cyc), 32'(n + 20));

    step();
    step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
